// File: rtl/vend_pkg.sv
// Definitions shared by the vending FSM and the change dispenser.
// Contents: one-hot state encodings, coin denominations, and seven-segment
// digit patterns (active-low segments g..a) used by the HEX tally displays.
package vend_pkg;

  // One-hot dispenser states; bit index equals position in the list below.
  localparam int unsigned StW     = 5;
  localparam logic [4:0]  StIdle  = 5'b00001;
  localparam logic [4:0]  StLoad  = 5'b00010;
  localparam logic [4:0]  StPulse = 5'b00100;
  localparam logic [4:0]  StGap   = 5'b01000;
  localparam logic [4:0]  StDone  = 5'b10000;

  // Coin denominations, largest first.
  localparam int unsigned CoinHi  = 10;
  localparam int unsigned CoinMid = 5;
  localparam int unsigned CoinLo  = 1;

  // Seven-segment patterns, active low, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SegBlank = 7'h7f;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] seg;
    seg = SegBlank;
    case (d)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = SegBlank;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter used to pace coin pulses and gaps.
// Ports:
//   CLOCK_27  in  system clock
//   KEY0      in  asynchronous active-low reset
//   load      in  load value into the counter this edge
//   value     in  value to load
//   expired   out high while the count is zero
module cycle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         CLOCK_27,
  input  logic         KEY0,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLOCK_27 or negedge KEY0) begin
    if (!KEY0) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser: pays out a captured amount as 10/5/1 hopper
// strobes, largest coin first, with timed pulse and gap phases.
// Ports:
//   CLOCK_27  in  system clock
//   KEY0      in  asynchronous active-low reset
//   start     in  request, honoured only when idle
//   amount    in  change value captured on an accepted start
//   abort     in  stop dispensing (ignored when idle or done)
//   busy      out high from LOAD through DONE
//   done      out 1-cycle pulse, full amount paid
//   aborted   out 1-cycle pulse, abort honoured
//   err       out 1-cycle pulse, request above MAX_AMT rejected
//   coin10/coin5/coin1  out registered hopper strobes
//   n10/n5/n1 out per-coin tallies for the current request, saturating at 7
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W     = 6,
  parameter int unsigned MAX_AMT   = 40,
  parameter int unsigned PULSE_CYC = 6_750_000,
  parameter int unsigned GAP_CYC   = 6_750_000
) (
  input  logic             CLOCK_27,
  input  logic             KEY0,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err,
  output logic             coin10,
  output logic             coin5,
  output logic             coin1,
  output logic [2:0]       n10,
  output logic [2:0]       n5,
  output logic [2:0]       n1
);

  localparam int unsigned MaxCyc = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  logic [StW-1:0]   state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       coin_q, coin_d;  // {10, 5, 1}; also remembers the coin in flight
  logic [2:0]       n10_q, n10_d, n5_q, n5_d, n1_q, n1_d;
  logic             done_q, done_d, aborted_q, aborted_d, err_q, err_d;
  logic             tmr_load, tmr_expired;
  logic [TimerW-1:0] tmr_value;

  function automatic logic [2:0] sat_inc(input logic [2:0] n);
    return (n == 3'd7) ? n : n + 3'd1;
  endfunction

  function automatic logic [AMT_W-1:0] coin_val(input logic [2:0] c);
    logic [AMT_W-1:0] v;
    v = AMT_W'(CoinLo);
    if (c[2]) v = AMT_W'(CoinHi);
    else if (c[1]) v = AMT_W'(CoinMid);
    return v;
  endfunction

  cycle_timer #(
    .W (TimerW)
  ) u_timer (
    .CLOCK_27 (CLOCK_27),
    .KEY0     (KEY0),
    .load     (tmr_load),
    .value    (tmr_value),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    coin_d    = coin_q;
    n10_d     = n10_q;
    n5_d      = n5_q;
    n1_d      = n1_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    err_d     = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      StIdle: begin
        // start beats a simultaneous abort: abort is not looked at here
        if (start) begin
          if (32'(amount) > MAX_AMT) begin
            err_d = 1'b1;
          end else begin
            state_d = StLoad;
            rem_d   = amount;
            n10_d   = '0;
            n5_d    = '0;
            n1_d    = '0;
          end
        end
      end
      StLoad: begin
        if (rem_q == '0) begin
          // nothing left to abort, so completion takes priority
          state_d = StDone;
          done_d  = 1'b1;
        end else if (abort) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else begin
          if (rem_q >= AMT_W'(CoinHi)) coin_d = 3'b100;
          else if (rem_q >= AMT_W'(CoinMid)) coin_d = 3'b010;
          else coin_d = 3'b001;
          tmr_load  = 1'b1;
          tmr_value = TimerW'(PULSE_CYC - 1);
          state_d   = StPulse;
        end
      end
      StPulse: begin
        if (abort) begin
          // a cut-short coin is neither tallied nor subtracted
          state_d   = StIdle;
          coin_d    = '0;
          aborted_d = 1'b1;
        end else if (tmr_expired) begin
          rem_d = rem_q - coin_val(coin_q);
          if (coin_q[2]) n10_d = sat_inc(n10_q);
          else if (coin_q[1]) n5_d = sat_inc(n5_q);
          else n1_d = sat_inc(n1_q);
          coin_d    = '0;
          tmr_load  = 1'b1;
          tmr_value = TimerW'(GAP_CYC - 1);
          state_d   = StGap;
        end
      end
      StGap: begin
        if (abort) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (tmr_expired) begin
          state_d = StLoad;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        coin_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_27 or negedge KEY0) begin
    if (!KEY0) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      coin_q    <= '0;
      n10_q     <= '0;
      n5_q      <= '0;
      n1_q      <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      coin_q    <= coin_d;
      n10_q     <= n10_d;
      n5_q      <= n5_d;
      n1_q      <= n1_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign aborted = aborted_q;
  assign err     = err_q;
  assign coin10  = coin_q[2];
  assign coin5   = coin_q[1];
  assign coin1   = coin_q[0];
  assign n10     = n10_q;
  assign n5      = n5_q;
  assign n1      = n1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed, table-driven bench for change_dispenser with PULSE_CYC=2, GAP_CYC=1.
// Cycle numbering: start is driven during cycle t; the k-th following negedge
// observes cycle t+k. Coin codes in sequences: 3=coin10, 2=coin5, 1=coin1.
module tb_change_dispenser;

  logic       CLOCK_27;
  logic       KEY0;
  logic       start;
  logic [5:0] amount;
  logic       abort;
  logic       busy, done, aborted, err;
  logic       coin10, coin5, coin1;
  logic [2:0] n10, n5, n1;

  int checks;
  int failures;

  change_dispenser #(
    .AMT_W     (6),
    .MAX_AMT   (40),
    .PULSE_CYC (2),
    .GAP_CYC   (1)
  ) dut (
    .CLOCK_27 (CLOCK_27),
    .KEY0     (KEY0),
    .start    (start),
    .amount   (amount),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .err      (err),
    .coin10   (coin10),
    .coin5    (coin5),
    .coin1    (coin1),
    .n10      (n10),
    .n5       (n5),
    .n1       (n1)
  );

  initial CLOCK_27 = 1'b0;
  always #5 CLOCK_27 = ~CLOCK_27;

  typedef struct {
    int          amt;
    int          ab_k;    // cycle during which abort is high (0: with start, -1: never)
    int          rs_k;    // cycle of a repeated start (-1: never)
    int          rs_amt;
    int          done_k;  // expected cycle of done/err/aborted, 0 = never
    int          err_k;
    int          abd_k;
    int          nc;      // coin strobes started
    logic [11:0] seq;     // coin codes, first coin in [1:0]
    int          e10, e5, e1;
    int          hi;      // total strobe-high cycles
    int          busy_c;  // cycles with busy high
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] sq(input int a, b, c, d, e, f);
    return {f[1:0], e[1:0], d[1:0], c[1:0], b[1:0], a[1:0]};
  endfunction

  function automatic vec_t mk(input int amt, ab_k, rs_k, rs_amt, done_k, err_k, abd_k,
                              nc, input logic [11:0] seq, input int e10, e5, e1, hi,
                              busy_c);
    vec_t v;
    v.amt = amt; v.ab_k = ab_k; v.rs_k = rs_k; v.rs_amt = rs_amt;
    v.done_k = done_k; v.err_k = err_k; v.abd_k = abd_k; v.nc = nc; v.seq = seq;
    v.e10 = e10; v.e5 = e5; v.e1 = e1; v.hi = hi; v.busy_c = busy_c;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0d want=%0d", nm, idx, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int k, ek, done_k, err_k, abd_k, nc, hi, busy_c, multi;
    logic [2:0]  prev, cur, rose;
    logic [11:0] seq;
    k = 0; ek = 0; done_k = 0; err_k = 0; abd_k = 0;
    nc = 0; hi = 0; busy_c = 0; multi = 0;
    prev = '0; seq = '0;
    start  = 1'b1;
    amount = 6'(v.amt);
    abort  = (v.ab_k == 0);
    while (1) begin
      @(negedge CLOCK_27);
      k++;
      cur  = {coin10, coin5, coin1};
      rose = cur & ~prev;
      prev = cur;
      for (int b = 2; b >= 0; b--) begin
        if (rose[b]) begin
          if (nc < 6) seq[2*nc +: 2] = 2'(b + 1);
          nc++;
        end
      end
      hi += $countones(cur);
      if ($countones(cur) > 1) multi++;
      if (busy) busy_c++;
      if (done && done_k == 0) done_k = k;
      if (err && err_k == 0) err_k = k;
      if (aborted && abd_k == 0) abd_k = k;
      if (ek == 0 && (done || err || aborted)) ek = k;
      start = (k == v.rs_k);
      if (k == v.rs_k) amount = 6'(v.rs_amt);
      abort = (k == v.ab_k);
      if (k >= 60 || (ek != 0 && k >= ek + 2)) break;
    end
    start = 1'b0;
    abort = 1'b0;
    chk("done_cycle", idx, done_k, v.done_k);
    chk("err_cycle", idx, err_k, v.err_k);
    chk("aborted_cycle", idx, abd_k, v.abd_k);
    chk("coin_count", idx, nc, v.nc);
    chk("coin_order", idx, int'(seq), int'(v.seq));
    chk("n10", idx, int'(n10), v.e10);
    chk("n5", idx, int'(n5), v.e5);
    chk("n1", idx, int'(n1), v.e1);
    chk("strobe_high_cycles", idx, hi, v.hi);
    chk("busy_cycles", idx, busy_c, v.busy_c);
    chk("one_hot_strobes", idx, multi, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    KEY0     = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    amount   = '0;

    //        amt ab  rs rsa done err abd nc  seq                    n10 n5 n1 hi busy
    vecs.push_back(mk( 0, -1, -1,  0,  2,  0,  0, 0, sq(0,0,0,0,0,0), 0, 0, 0,  0,  2));
    vecs.push_back(mk(17, -1, -1,  0, 18,  0,  0, 4, sq(3,2,1,1,0,0), 1, 1, 2,  8, 18));
    vecs.push_back(mk(45, -1, -1,  0,  0,  1,  0, 0, sq(0,0,0,0,0,0), 1, 1, 2,  0,  0));
    vecs.push_back(mk(40, -1, -1,  0, 18,  0,  0, 4, sq(3,3,3,3,0,0), 4, 0, 0,  8, 18));
    vecs.push_back(mk( 9, -1, -1,  0, 22,  0,  0, 5, sq(2,1,1,1,1,0), 0, 1, 4, 10, 22));
    vecs.push_back(mk(63, -1, -1,  0,  0,  1,  0, 0, sq(0,0,0,0,0,0), 0, 1, 4,  0,  0));
    vecs.push_back(mk(24, -1, -1,  0, 26,  0,  0, 6, sq(3,3,1,1,1,1), 2, 0, 4, 12, 26));
    vecs.push_back(mk(41, -1, -1,  0,  0,  1,  0, 0, sq(0,0,0,0,0,0), 2, 0, 4,  0,  0));
    // abort during the second coin10 pulse
    vecs.push_back(mk(20,  6, -1,  0,  0,  0,  7, 2, sq(3,3,0,0,0,0), 1, 0, 0,  3,  6));
    // second start while busy is ignored
    vecs.push_back(mk( 6, -1,  3, 40, 10,  0,  0, 2, sq(2,1,0,0,0,0), 0, 1, 1,  4, 10));
    // start and abort together in IDLE: start wins
    vecs.push_back(mk( 5,  0, -1,  0,  6,  0,  0, 1, sq(2,0,0,0,0,0), 0, 1, 0,  2,  6));
    // abort during DONE is ignored
    vecs.push_back(mk( 1,  6, -1,  0,  6,  0,  0, 1, sq(1,0,0,0,0,0), 0, 0, 1,  2,  6));
    // abort in GAP keeps the completed coin, abort in LOAD likewise
    vecs.push_back(mk( 7,  4, -1,  0,  0,  0,  5, 1, sq(2,0,0,0,0,0), 0, 1, 0,  2,  4));
    vecs.push_back(mk(12,  5, -1,  0,  0,  0,  6, 1, sq(3,0,0,0,0,0), 1, 0, 0,  2,  5));

    repeat (2) @(negedge CLOCK_27);
    chk("reset_outputs", -1,
        int'({busy, done, aborted, err, coin10, coin5, coin1, n10, n5, n1}), 0);
    KEY0 = 1'b1;
    @(negedge CLOCK_27);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i]);
    end

    // Asynchronous reset in the middle of the coin1 pulse of amount=9.
    start  = 1'b1;
    amount = 6'd9;
    @(negedge CLOCK_27);
    start = 1'b0;
    repeat (5) @(negedge CLOCK_27);
    chk("pre_reset_coin1", 100, int'(coin1), 1);
    chk("pre_reset_n5", 100, int'(n5), 1);
    KEY0 = 1'b0;
    #1;
    chk("async_reset_outputs", 100,
        int'({busy, done, aborted, err, coin10, coin5, coin1, n10, n5, n1}), 0);
    @(negedge CLOCK_27);
    KEY0 = 1'b1;
    @(negedge CLOCK_27);
    run_vec(101, mk(1, -1, -1, 0, 6, 0, 0, 1, sq(1,0,0,0,0,0), 0, 0, 1, 2, 6));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
